conv_window_feeder: RTL



---
 rtl/conv_pkg.sv | 31 +++
 rtl/nbr_addr_gen.sv | 63 ++++++
 rtl/conv_window_feeder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the conv window feeder and its neighbour
// address generator.
//   - state_t      : feeder FSM encoding
//   - PROV_*       : column flag values presented to the conv MAC stage
//   - SLOT_*       : window slot order (w1..w9 = slot 0..8)
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EMIT  = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   localparam logic [1:0] PROV_LEFT  = 2'b11;
   localparam logic [1:0] PROV_RIGHT = 2'b10;
   localparam logic [1:0] PROV_MID   = 2'b00;

   localparam logic [3:0] SLOT_CENTER    = 4'd0;
   localparam logic [3:0] SLOT_RIGHT     = 4'd1;
   localparam logic [3:0] SLOT_LEFT      = 4'd2;
   localparam logic [3:0] SLOT_DOWNLEFT  = 4'd3;
   localparam logic [3:0] SLOT_UPRIGHT   = 4'd4;
   localparam logic [3:0] SLOT_DOWN      = 4'd5;
   localparam logic [3:0] SLOT_UP        = 4'd6;
   localparam logic [3:0] SLOT_DOWNRIGHT = 4'd7;
   localparam logic [3:0] SLOT_UPLEFT    = 4'd8;
   localparam logic [3:0] SLOT_LAST      = SLOT_UPLEFT;

endpackage

// File: rtl/nbr_addr_gen.sv
// nbr_addr_gen: combinational neighbour address/validity generator.
// Given the current pixel index, its column and the map geometry, returns the
// map-relative address of one window slot (modulo 2^ADDR_W) and whether that
// neighbour lies inside the map.
// Ports:
//   i_p     [9:0]        current pixel index
//   i_col   [4:0]        column of i_p (0..m-1)
//   i_m     [4:0]        map side length
//   i_m2    [9:0]        pixel count (m*m)
//   i_slot  [3:0]        slot 0..8 in w1..w9 order
//   o_off   [ADDR_W-1:0] pixel index of the neighbour (before base offset)
//   o_vld                neighbour exists
module nbr_addr_gen
   import conv_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic [9:0]        i_p,
   input  logic [4:0]        i_col,
   input  logic [4:0]        i_m,
   input  logic [9:0]        i_m2,
   input  logic [3:0]        i_slot,
   output logic [ADDR_W-1:0] o_off,
   output logic              o_vld
);

   logic [ADDR_W-1:0] w_p;
   logic [ADDR_W-1:0] w_m;
   logic [ADDR_W-1:0] w_one;
   logic [10:0]       w_down_lim;
   logic              w_rt;
   logic              w_lt;
   logic              w_dn;
   logic              w_up;

   assign w_p        = ADDR_W'(i_p);
   assign w_m        = ADDR_W'(i_m);
   assign w_one      = ADDR_W'(1);
   // Extra bit keeps matrix2-m from wrapping for tiny maps.
   assign w_down_lim = {1'b0, i_m2} - {6'b0, i_m};
   assign w_rt       = (i_col != (i_m - 5'd1));
   assign w_lt       = (i_col != 5'd0);
   assign w_dn       = ({1'b0, i_p} < w_down_lim);
   assign w_up       = ({5'b0, i_m} <= i_p);

   always_comb begin
      o_off = w_p;
      o_vld = 1'b1;
      case (i_slot)
         SLOT_CENTER:    begin o_off = w_p;                 o_vld = 1'b1;        end
         SLOT_RIGHT:     begin o_off = w_p + w_one;         o_vld = w_rt;        end
         SLOT_LEFT:      begin o_off = w_p - w_one;         o_vld = w_lt;        end
         SLOT_DOWNLEFT:  begin o_off = w_p + w_m - w_one;   o_vld = w_dn & w_lt; end
         SLOT_UPRIGHT:   begin o_off = w_p - w_m + w_one;   o_vld = w_up & w_rt; end
         SLOT_DOWN:      begin o_off = w_p + w_m;           o_vld = w_dn;        end
         SLOT_UP:        begin o_off = w_p - w_m;           o_vld = w_up;        end
         SLOT_DOWNRIGHT: begin o_off = w_p + w_m + w_one;   o_vld = w_dn & w_rt; end
         SLOT_UPLEFT:    begin o_off = w_p - w_m - w_one;   o_vld = w_up & w_lt; end
         default:        begin o_off = w_p;                 o_vld = 1'b0;        end
      endcase
   end

endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: walks a square feature map in single-port RAM and
// presents the 3x3 neighbourhood of every pixel to the conv MAC stage.
// Each pixel takes 11 cycles: 9 FETCH slots, 1 WAIT, 1 EMIT (conv_en high).
// Out-of-map neighbours are not read; their window slot is presented as 0.
// Optional feature: define CONV_FEEDER_DENSE_EN to enable dense mode
// (slots read base+9*p+k, no boundary gating, dense_en=1 for the pass).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a pass (only honoured in IDLE)
//   base_addr [ADDR_W-1:0]   address of pixel 0
//   matrix [4:0]             map side, matrix2 [9:0] pixel count
//   dense_mode               dense pass request
//   mem_re, mem_addr         RAM read port; mem_data returns one cycle later
//   w1..w9 [SIZE-1:0]        window: center, right, left, downleft, upright,
//                            down, up, downright, upleft
//   i [9:0], prov [1:0]      pixel index and column flag of the window
//   conv_en                  one-cycle window strobe
//   dense_en, busy, done     pass status
module conv_window_feeder
   import conv_pkg::*;
#(
   parameter int SIZE   = 23,
   parameter int ADDR_W = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [4:0]             matrix,
   input  logic [9:0]             matrix2,
   input  logic                   dense_mode,
   output logic                   mem_re,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic [SIZE-1:0]        mem_data,
   output logic signed [SIZE-1:0] w1,
   output logic signed [SIZE-1:0] w2,
   output logic signed [SIZE-1:0] w3,
   output logic signed [SIZE-1:0] w4,
   output logic signed [SIZE-1:0] w5,
   output logic signed [SIZE-1:0] w6,
   output logic signed [SIZE-1:0] w7,
   output logic signed [SIZE-1:0] w8,
   output logic signed [SIZE-1:0] w9,
   output logic [9:0]             i,
   output logic [1:0]             prov,
   output logic                   conv_en,
   output logic                   dense_en,
   output logic                   busy,
   output logic                   done
);

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_W-1:0]     r_base;
   logic [4:0]            r_m;
   logic [9:0]            r_m2;
   logic [9:0]            r_p;
   logic [4:0]            r_col;
   logic [3:0]            r_slot;
   logic                  r_dense;
   logic                  r_cap_act;
   logic [3:0]            r_cap_slot;
   logic                  r_cap_vld;
   logic signed [SIZE-1:0] r_cap [0:7];
   logic signed [SIZE-1:0] r_w   [0:8];
   logic [9:0]            r_i;
   logic [1:0]            r_prov;

   logic [ADDR_W-1:0]     w_gen_off;
   logic                  w_gen_vld;
   logic [ADDR_W-1:0]     w_off;
   logic                  w_vld;
   logic                  w_last;
   logic [1:0]            w_prov;

   nbr_addr_gen #(.ADDR_W(ADDR_W)) u_nbr (
      .i_p    (r_p),
      .i_col  (r_col),
      .i_m    (r_m),
      .i_m2   (r_m2),
      .i_slot (r_slot),
      .o_off  (w_gen_off),
      .o_vld  (w_gen_vld)
   );

`ifdef CONV_FEEDER_DENSE_EN
   // Dense windows are nine consecutive words starting at 9*p.
   assign w_off = r_dense ? (ADDR_W'({r_p, 3'b000}) + ADDR_W'(r_p) + ADDR_W'(r_slot))
                          : w_gen_off;
   assign w_vld = r_dense | w_gen_vld;
`else
   logic w_unused_dense;
   assign w_unused_dense = dense_mode;
   assign w_off = w_gen_off;
   assign w_vld = w_gen_vld;
`endif

   assign w_last = (r_p == (r_m2 - 10'd1));

   always_comb begin
      w_prov = PROV_MID;
      if (!r_dense) begin
         if (r_col == 5'd0)
            w_prov = PROV_LEFT;
         else if (r_col == (r_m - 5'd1))
            w_prov = PROV_RIGHT;
      end
   end

   // Next-state and strobe outputs
   always_comb begin
      w_next   = r_state;
      mem_re   = 1'b0;
      mem_addr = '0;
      conv_en  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start)
               w_next = (matrix2 != 10'd0) ? ST_FETCH : ST_FIN;
         end
         ST_FETCH: begin
            busy = 1'b1;
            if (w_vld) begin
               mem_re   = 1'b1;
               mem_addr = r_base + w_off;
            end
            if (r_slot == SLOT_LAST)
               w_next = ST_WAIT;
         end
         ST_WAIT: begin
            busy   = 1'b1;
            w_next = ST_EMIT;
         end
         ST_EMIT: begin
            busy    = 1'b1;
            conv_en = 1'b1;
            w_next  = w_last ? ST_FIN : ST_FETCH;
         end
         ST_FIN: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Control state, pass parameters and presented window
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_base     <= '0;
         r_m        <= '0;
         r_m2       <= '0;
         r_p        <= '0;
         r_col      <= '0;
         r_slot     <= '0;
         r_dense    <= 1'b0;
         r_cap_act  <= 1'b0;
         r_cap_slot <= '0;
         r_cap_vld  <= 1'b0;
         r_i        <= '0;
         r_prov     <= '0;
         for (int k = 0; k < 9; k++)
            r_w[k] <= '0;
      end else begin
         r_state    <= w_next;
         // A read issued this cycle returns next cycle; remember where it goes.
         r_cap_act  <= (r_state == ST_FETCH);
         r_cap_slot <= r_slot;
         r_cap_vld  <= w_vld;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_base <= base_addr;
                  r_m    <= matrix;
                  r_m2   <= matrix2;
                  r_p    <= '0;
                  r_col  <= '0;
                  r_slot <= '0;
`ifdef CONV_FEEDER_DENSE_EN
                  r_dense <= dense_mode;
`else
                  r_dense <= 1'b0;
`endif
               end
            end
            ST_FETCH: begin
               r_slot <= (r_slot == SLOT_LAST) ? 4'd0 : r_slot + 4'd1;
            end
            ST_WAIT: begin
               // Slot 8 data arrives this cycle, so merge it directly.
               for (int k = 0; k < 8; k++)
                  r_w[k] <= r_cap[k];
               r_w[8] <= r_cap_vld ? $signed(mem_data) : '0;
               r_i    <= r_p;
               r_prov <= w_prov;
            end
            ST_EMIT: begin
               if (!w_last) begin
                  r_p   <= r_p + 10'd1;
                  r_col <= (r_col == (r_m - 5'd1)) ? 5'd0 : r_col + 5'd1;
               end
            end
            ST_FIN: begin
               r_dense <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Slot capture, one cycle behind the read
   always_ff @(posedge clk) begin
      if (r_cap_act && (r_cap_slot != SLOT_LAST))
         r_cap[r_cap_slot[2:0]] <= r_cap_vld ? $signed(mem_data) : '0;
   end

   assign w1       = r_w[0];
   assign w2       = r_w[1];
   assign w3       = r_w[2];
   assign w4       = r_w[3];
   assign w5       = r_w[4];
   assign w6       = r_w[5];
   assign w7       = r_w[6];
   assign w8       = r_w[7];
   assign w9       = r_w[8];
   assign i        = r_i;
   assign prov     = r_prov;
   assign dense_en = r_dense;

endmodule
